// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode codes, sequencer state encoding and datapath width.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SHL  = 4'b0101;
  localparam logic [3:0] ALU_SHR  = 4'b0110;
  localparam logic [3:0] ALU_MLO  = 4'b1101;
  localparam logic [3:0] ALU_MHI  = 4'b1110;
  localparam logic [3:0] ALU_SQRT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC_LO = 2'd1,
    ST_EXEC_HI = 2'd2,
    ST_RESP    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Control stage in front of the 8-bit ALU: operand registers, settle window, accumulator, 16-bit multiply.
// Define ALU_SEQ_OVERLAP_EN to accept the next command in the same cycle as the response handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [3:0]  MODE_MLO      = ALU_MLO,
  parameter logic [3:0]  MODE_MHI      = ALU_MHI
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  input  logic                cmd_use_acc,
  input  logic                cmd_wide,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [3:0]          alu_mode,
  output logic                alu_ee,
  output logic                alu_eo,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_carry,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic [DATA_W-1:0]   acc
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  seq_state_t          state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                wide_reg, wide_next;
  logic [DATA_W-1:0]   lo_reg, lo_next;
  logic [DATA_W-1:0]   a_reg, a_next;
  logic [DATA_W-1:0]   b_reg, b_next;
  logic [3:0]          mode_reg, mode_next;
  logic [2*DATA_W-1:0] data_reg, data_next;
  logic                carry_reg, carry_next;
  logic                zero_reg, zero_next;
  logic [DATA_W-1:0]   acc_reg, acc_next;

  logic                can_accept;
  logic                accept;
  logic                settle_done;
  logic [DATA_W-1:0]   acc_src;
  logic [2*DATA_W-1:0] wide_result;

`ifdef ALU_SEQ_OVERLAP_EN
  assign can_accept = (state_reg == ST_IDLE) || ((state_reg == ST_RESP) && rsp_ready);
`else
  assign can_accept = (state_reg == ST_IDLE);
`endif

  assign cmd_ready   = can_accept & ~reset;
  assign accept      = cmd_valid & cmd_ready;
  assign settle_done = (cnt_reg == SETTLE_LAST);
  // In RESP the accumulator equals the response low byte; an overlapped accept takes it from there.
  assign acc_src     = (state_reg == ST_RESP) ? data_reg[DATA_W-1:0] : acc_reg;
  assign wide_result = {alu_out, lo_reg};

  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_mode  = mode_reg;
  assign alu_ee    = (state_reg == ST_EXEC_LO) || (state_reg == ST_EXEC_HI);
  assign alu_eo    = alu_ee;
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_data  = data_reg;
  assign rsp_carry = carry_reg;
  assign rsp_zero  = zero_reg;
  assign acc       = acc_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wide_next  = wide_reg;
    lo_next    = lo_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    mode_next  = mode_reg;
    data_next  = data_reg;
    carry_next = carry_reg;
    zero_next  = zero_reg;
    acc_next   = acc_reg;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_IDLE;
      end
      ST_EXEC_LO: begin
        if (settle_done) begin
          cnt_next = '0;
          if (wide_reg) begin
            lo_next    = alu_out;
            mode_next  = MODE_MHI;
            state_next = ST_EXEC_HI;
          end else begin
            data_next  = {{DATA_W{1'b0}}, alu_out};
            carry_next = alu_carry;
            zero_next  = alu_zero;
            acc_next   = alu_out;
            state_next = ST_RESP;
          end
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_EXEC_HI: begin
        if (settle_done) begin
          cnt_next   = '0;
          data_next  = wide_result;
          carry_next = alu_carry;
          zero_next  = (wide_result == '0);
          acc_next   = lo_reg;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Placed last so an overlapped accept in RESP overrides the return to IDLE.
    if (accept) begin
      a_next     = cmd_use_acc ? acc_src : cmd_a;
      b_next     = cmd_b;
      mode_next  = cmd_op;
      wide_next  = cmd_wide & (cmd_op == MODE_MLO);
      cnt_next   = '0;
      state_next = ST_EXEC_LO;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wide_reg  <= 1'b0;
      lo_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= '0;
      data_reg  <= '0;
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wide_reg  <= wide_next;
      lo_reg    <= lo_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      mode_reg  <= mode_next;
      data_reg  <= data_next;
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
      acc_reg   <= acc_next;
    end
  end

endmodule
